// File: rtl/cp_insert_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cp_insert_buffer
// Purpose  : Ping-pong symbol buffer that collects FFT_SIZE complex samples
//            while the upstream gate is high and re-emits each symbol with a
//            cyclic prefix (last CP_LEN samples) prepended.
// Revision : 1.0 - initial release
// ============================================================================
module cp_insert_buffer #(
    parameter int DATA_W   = 16,
    parameter int FFT_SIZE = 1024,
    parameter int ADDR_W   = 10,
    parameter int CP_LEN   = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_gate,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_sop,
    output logic              out_eop
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FFT_SIZE - 1);
    localparam logic [ADDR_W-1:0] c_CP_START  = ADDR_W'(FFT_SIZE - CP_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CP   = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // Both banks live in one array; the bank index is the address MSB.
    logic [2*DATA_W-1:0] mem_q [0:2*FFT_SIZE-1];

    // Write side
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        full_q,    full_d;

    // Read side
    logic [1:0]        state_q,   state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // Output stage
    logic              out_valid_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic [DATA_W-1:0] out_re_q;
    logic [DATA_W-1:0] out_im_q;

    logic w_accept;
    logic w_wr_done;
    logic w_rd_en;
    logic w_rd_done;
    logic w_rd_sop;
    logic w_rd_eop;
    logic w_next_full;

    assign in_ready  = ~full_q[wr_bank_q];
    assign w_accept  = in_valid & in_gate & in_ready;
    assign w_wr_done = w_accept && (wr_addr_q == c_LAST_ADDR);

    // The bank the reader moves to next may be completed by the writer in the
    // very cycle the reader finishes; forwarding that avoids an IDLE bubble.
    assign w_next_full = full_q[~rd_bank_q] | (w_wr_done & (wr_bank_q != rd_bank_q));

    // Write-side next state: address advance and bank swap at end of symbol.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        if (w_accept) begin
            if (w_wr_done) begin
                wr_addr_d = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // Bank-full flags: writer sets its bank, reader clears its own; they never
    // target the same bank in one cycle because the writer avoids full banks.
    always_comb begin
        full_d = full_q;
        if (w_wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (w_rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Sample storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= {in_re, in_im};
        end
    end

    // Write-side and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Read FSM next state: prefix region, then body, then next bank or idle.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = S_CP;
                    rd_addr_d = c_CP_START;
                end
            end
            S_CP: begin
                if (w_rd_en) begin
                    if (rd_addr_q == c_LAST_ADDR) begin
                        state_d   = S_BODY;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (w_rd_en) begin
                    if (rd_addr_q == c_LAST_ADDR) begin
                        rd_bank_d = ~rd_bank_q;
                        if (w_next_full) begin
                            state_d   = S_CP;
                            rd_addr_d = c_CP_START;
                        end else begin
                            state_d   = S_IDLE;
                            rd_addr_d = '0;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                rd_addr_d = '0;
            end
        endcase
    end

    // Read FSM outputs: issue a read only when the output stage can take it.
    always_comb begin
        w_rd_en   = (state_q != S_IDLE) && (out_ready || !out_valid_q);
        w_rd_sop  = (state_q == S_CP)   && (rd_addr_q == c_CP_START);
        w_rd_eop  = (state_q == S_BODY) && (rd_addr_q == c_LAST_ADDR);
        w_rd_done = w_rd_en && w_rd_eop;
    end

    // Output stage: the RAM read lands here directly; it holds while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else if (w_rd_en) begin
            out_valid_q            <= 1'b1;
            out_sop_q              <= w_rd_sop;
            out_eop_q              <= w_rd_eop;
            {out_re_q, out_im_q}   <= mem_q[{rd_bank_q, rd_addr_q}];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule
`default_nettype wire

// File: doc/cp_insert_buffer.md
Name: cp_insert_buffer

Overview:
- Sits directly downstream of the frame counter in the OFDM transmit chain.
- Collects one OFDM symbol of FFT_SIZE complex time-domain samples. Accepts only while the upstream gate (frame counter control_signal) is high.
- Re-emits each symbol with a cyclic prefix prepended: its last CP_LEN samples, then all FFT_SIZE samples.
- Two RAM banks in ping-pong, so writing of symbol n+1 overlaps readout of symbol n. Valid/ready handshakes on both sides.

Parameters:
- DATA_W, 16, width of each of the I and Q components.
- FFT_SIZE, 1024, samples per symbol (power of two).
- ADDR_W, 10, log2(FFT_SIZE).
- CP_LEN, 256, cyclic prefix length. Legal range 1 <= CP_LEN < FFT_SIZE.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  upstream sample valid (frame counter ready_out).
- in_gate  in  1  symbol-region gate (frame counter control_signal).
- in_re  in  DATA_W  sample real part.
- in_im  in  DATA_W  sample imaginary part.
- in_ready  out  1  buffer can accept a sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_re  out  DATA_W  output real part.
- out_im  out  DATA_W  output imaginary part.
- out_sop  out  1  marks first CP sample of a symbol.
- out_eop  out  1  marks last body sample of a symbol.

Behaviour:
- Reset (async, active-high):
  - Both bank-full flags, wr_bank, rd_bank, wr_addr and rd_addr clear to 0.
  - FSM goes to IDLE.
  - out_valid, out_sop, out_eop, out_re and out_im are 0.
  - in_ready = 1 (it is combinational: !full[wr_bank]).
  - Reset mid-symbol discards all partial and buffered data.
- Write side:
  - A sample is accepted on a clock edge when in_valid && in_ready && in_gate.
  - An accepted sample is written to bank wr_bank at wr_addr, then wr_addr increments.
  - in_valid while in_gate=0: sample is dropped and wr_addr is unchanged.
  - On acceptance at wr_addr = FFT_SIZE-1: set full[wr_bank], toggle wr_bank, wr_addr wraps to 0.
  - in_ready is low while the current write bank is full. The upstream must hold its sample until accepted.
- Read FSM states:
  - IDLE -> CP when full[rd_bank]; rd_addr loads FFT_SIZE-CP_LEN.
  - CP: reads addresses FFT_SIZE-CP_LEN .. FFT_SIZE-1. After the last one, go to BODY with rd_addr = 0.
  - BODY: reads addresses 0 .. FFT_SIZE-1.
  - On issuing the BODY read of FFT_SIZE-1: clear full[rd_bank] and toggle rd_bank.
  - Then go to CP if the new rd_bank is full (no bubble between symbols), else to IDLE.
  - Each symbol therefore emits exactly FFT_SIZE+CP_LEN samples.
- Output pipeline:
  - RAM read has 1-cycle latency, into a registered output stage.
  - A read is issued only when the output stage is empty or being consumed (out_ready || !out_valid). There must be no sample loss or duplication under arbitrary out_ready patterns.
  - While out_valid=1 && out_ready=0, out_re, out_im, out_sop and out_eop hold stable.
- Latency: last input sample accepted at edge k gives first CP sample with out_valid=1 after edge k+2, when the bank was idle and out_ready=1.
- Flags: out_sop=1 only with the first CP sample; out_eop=1 only with body sample FFT_SIZE-1. Both are qualified by out_valid.
- Simultaneous events:
  - Writer setting full on one bank in the same cycle the reader clears the other is legal. Both take effect.
  - The writer never writes a bank flagged full, so set and clear of the same bank cannot coincide.
- Throughput: with out_ready held at 1, output is continuous. Input is backpressured to an average of FFT_SIZE samples per FFT_SIZE+CP_LEN cycles.

Test Plan:
- Single symbol, ramp re=0..1023, im=~re, gate=1, out_ready=1 -> 1280 outputs: re 768..1023 then 0..1023; sop on re=768, eop on final re=1023; first out_valid 2 cycles after last input.
- Random out_ready (50%) over 4 symbols -> output sequence identical to the first test per symbol; data/flags stable during stalls; no drops or duplicates.
- out_ready=0, feed 3 symbols -> in_ready drops after the 2048th accepted sample; 3rd symbol stalls. Raising out_ready resumes and all 3 symbols emerge in order.
- in_gate toggling (low for samples 100..199 of 1124 valid inputs) -> exactly 1024 samples stored (those with gate=1, in order); output matches them.
- Reset asserted mid-BODY of symbol 1 with symbol 2 buffered -> out_valid=0 immediately, in_ready=1. A fresh symbol afterwards outputs correctly with no stale data.
- Continuous input, out_ready=1, CP_LEN=1 and CP_LEN=FFT_SIZE-1 builds -> gapless output, per-symbol lengths 1025 and 2047, correct prefix content.
